exe_stage: RTL and testbench

//  Execute stage of the 5-stage pipeline; consumes the ID/EX register outputs directly.

---
 rtl/exe_pkg.sv | 41 ++++
 rtl/exe_if.sv | 40 ++++
 rtl/exe_muldiv.sv | 116 +++++++++++
 rtl/exe_stage.sv | 86 ++++++++
 tb/tb_exe_stage.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: operation codes, branch types,
// multiply/divide sequencer states and a decode helper.
package exe_pkg;

   typedef enum logic [3:0] {
      CMD_ADD  = 4'b0000,
      CMD_SUB  = 4'b0010,
      CMD_AND  = 4'b0100,
      CMD_OR   = 4'b0101,
      CMD_NOR  = 4'b0110,
      CMD_XOR  = 4'b0111,
      CMD_SLL  = 4'b1000,
      CMD_SRL  = 4'b1010,
      CMD_SRA  = 4'b1011,
      CMD_MUL  = 4'b1100,
      CMD_DIVU = 4'b1101
   } exe_cmd_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_BEZ  = 2'b01,
      BR_BNE  = 2'b10,
      BR_JMP  = 2'b11
   } br_type_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_BUSY = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   typedef enum logic {
      MD_MUL  = 1'b0,
      MD_DIVU = 1'b1
   } md_op_e;

   function automatic logic is_md_cmd(input logic [3:0] cmd);
      return (cmd == CMD_MUL) || (cmd == CMD_DIVU);
   endfunction

endpackage

// File: rtl/exe_if.sv
// ID/EX-to-EX/MEM bundle of the execute stage. master = pipeline side driving
// the ID/EX fields, slave = the execute stage itself.
interface exe_if #(parameter int DW = 32);
   logic [4:0]    dest_in;
   logic [DW-1:0] readdata1;
   logic [DW-1:0] readdata2;
   logic [DW-1:0] Immediate;
   logic [DW-1:0] data1;
   logic [DW-1:0] data2;
   logic          WB_En_in;
   logic          MEM_R_En_in;
   logic          MEM_W_En_in;
   logic [1:0]    BR_Type;
   logic [3:0]    EXE_Cmd;
   logic [DW-1:0] PC;

   logic [DW-1:0] alu_result;
   logic [DW-1:0] st_value;
   logic [4:0]    dest;
   logic          WB_En;
   logic          MEM_R_En;
   logic          MEM_W_En;
   logic          br_taken;
   logic [DW-1:0] br_addr;
   logic          stall;

   modport master (
      output dest_in, readdata1, readdata2, Immediate, data1, data2,
             WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type, EXE_Cmd, PC,
      input  alu_result, st_value, dest, WB_En, MEM_R_En, MEM_W_En,
             br_taken, br_addr, stall
   );

   modport slave (
      input  dest_in, readdata1, readdata2, Immediate, data1, data2,
             WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type, EXE_Cmd, PC,
      output alu_result, st_value, dest, WB_En, MEM_R_En, MEM_W_En,
             br_taken, br_addr, stall
   );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative unsigned multiply / restoring divide, one result bit per cycle.
// busy covers the launch cycle plus every iteration; result is valid in DONE.
module exe_muldiv
   import exe_pkg::*;
#(
   parameter int DW       = 32,
   parameter int MD_ITERS = DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  md_op_e        op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result
);

   localparam int CW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;

   md_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   md_op_e        op_q, op_d;
   logic [DW-1:0] acc_q, acc_d;   // product accumulator / partial remainder
   logic [DW-1:0] x_q, x_d;       // shifted multiplicand / dividend becoming quotient
   logic [DW-1:0] y_q, y_d;       // shifted multiplier / divisor

   logic [DW:0]   rem_sh_s;
   logic [DW:0]   trial_s;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_MUL;
         acc_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Next-state and single-step datapath
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      x_d      = x_q;
      y_d      = y_q;
      rem_sh_s = {acc_q, x_q[DW-1]};
      trial_s  = rem_sh_s - {1'b0, y_q};

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               op_d    = op;
               acc_d   = '0;
               x_d     = a;
               y_d     = b;
               cnt_d   = '0;
               state_d = MD_BUSY;
            end else begin
               state_d = MD_IDLE;
            end
         end
         MD_BUSY: begin
            if (op_q == MD_MUL) begin
               acc_d = acc_q + (y_q[0] ? x_q : '0);
               x_d   = x_q << 1;
               y_d   = y_q >> 1;
            end else if (!trial_s[DW]) begin
               // Divisor fits: keep the difference and shift in a 1.
               // A zero divisor always fits, which yields an all-ones quotient.
               acc_d = trial_s[DW-1:0];
               x_d   = {x_q[DW-2:0], 1'b1};
            end else begin
               acc_d = rem_sh_s[DW-1:0];
               x_d   = {x_q[DW-2:0], 1'b0};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(MD_ITERS - 1)) begin
               state_d = MD_DONE;
            end else begin
               state_d = MD_BUSY;
            end
         end
         MD_DONE: begin
            state_d = MD_IDLE;
         end
         default: begin
            state_d = MD_IDLE;
         end
      endcase
   end

   // Handshake and result presentation
   always_comb begin
      busy = ((state_q == MD_IDLE) && start) || (state_q == MD_BUSY);
      done = (state_q == MD_DONE);
      if (state_q == MD_DONE) begin
         result = (op_q == MD_MUL) ? acc_q : x_q;
      end else begin
         result = '0;
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU and branch unit, bubble gating of the
// memory/write-back controls, and the iterative MUL/DIVU unit that raises stall.
module exe_stage
   import exe_pkg::*;
#(
   parameter int DW       = 32,
   parameter int MD_ITERS = DW
) (
   input  logic clk,
   input  logic rst,
   exe_if.slave bus
);

   logic          md_start_s;
   md_op_e        md_op_s;
   logic          md_busy_s;
   logic          md_done_s;
   logic [DW-1:0] md_result_s;
   logic [DW-1:0] alu_s;
   logic [4:0]    shamt_s;
   logic          stall_s;
   logic          br_cond_s;

   assign md_start_s = is_md_cmd(bus.EXE_Cmd);
   assign md_op_s    = (bus.EXE_Cmd == CMD_DIVU) ? MD_DIVU : MD_MUL;

   exe_muldiv #(
      .DW       (DW),
      .MD_ITERS (MD_ITERS)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start_s),
      .op     (md_op_s),
      .a      (bus.data1),
      .b      (bus.data2),
      .busy   (md_busy_s),
      .done   (md_done_s),
      .result (md_result_s)
   );

   // Single-cycle ALU; MUL/DIVU show their registered result only in DONE
   always_comb begin
      shamt_s = bus.data2[4:0];
      alu_s   = '0;
      case (bus.EXE_Cmd)
         CMD_ADD:  alu_s = bus.data1 + bus.data2;
         CMD_SUB:  alu_s = bus.data1 - bus.data2;
         CMD_AND:  alu_s = bus.data1 & bus.data2;
         CMD_OR:   alu_s = bus.data1 | bus.data2;
         CMD_NOR:  alu_s = ~(bus.data1 | bus.data2);
         CMD_XOR:  alu_s = bus.data1 ^ bus.data2;
         CMD_SLL:  alu_s = bus.data1 << shamt_s;
         CMD_SRL:  alu_s = bus.data1 >> shamt_s;
         CMD_SRA:  alu_s = $signed(bus.data1) >>> shamt_s;
         CMD_MUL,
         CMD_DIVU: alu_s = md_done_s ? md_result_s : '0;
         default:  alu_s = '0;
      endcase
   end

   // Branch condition decode
   always_comb begin
      br_cond_s = 1'b0;
      case (bus.BR_Type)
         BR_BEZ:  br_cond_s = (bus.readdata1 == '0);
         BR_BNE:  br_cond_s = (bus.readdata1 != bus.data2);
         BR_JMP:  br_cond_s = 1'b1;
         default: br_cond_s = 1'b0;
      endcase
   end

   // Reset masks stall so the pipeline is never frozen while being reset.
   assign stall_s        = md_busy_s & ~rst;

   assign bus.stall      = stall_s;
   assign bus.alu_result = alu_s;
   assign bus.st_value   = bus.readdata2;
   assign bus.dest       = bus.dest_in;
   assign bus.WB_En      = bus.WB_En_in    & ~stall_s;
   assign bus.MEM_R_En   = bus.MEM_R_En_in & ~stall_s;
   assign bus.MEM_W_En   = bus.MEM_W_En_in & ~stall_s;
   assign bus.br_taken   = br_cond_s & ~stall_s & ~rst;
   assign bus.br_addr    = bus.PC + (bus.Immediate << 2);

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage: ALU ops, branches, MUL/DIVU
// latency and results, mid-operation reset and back-to-back multiplies.
module tb_exe_stage;
   import exe_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   exe_if #(.DW(32)) bus ();

   exe_stage #(.DW(32), .MD_ITERS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
      bus.EXE_Cmd     = cmd;
      bus.data1       = a;
      bus.data2       = b;
      bus.BR_Type     = 2'b00;
      bus.WB_En_in    = 1'b1;
      bus.MEM_R_En_in = 1'b0;
      bus.MEM_W_En_in = 1'b0;
   endtask

   // Launches a MUL/DIVU (advancing one edge first when called from a DONE
   // cycle), counts stall cycles and checks the DONE-cycle outputs.
   task automatic md_run(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit advance);
      int   n;
      logic leak;
      set_op(cmd, a, b);
      bus.BR_Type = 2'b11;
      if (advance) tick();
      else #1;
      check({tag, "_stall_first"}, 32'(bus.stall), 32'd1);
      check({tag, "_wb_first"}, 32'(bus.WB_En), 32'd0);
      n    = 0;
      leak = 1'b0;
      while (bus.stall === 1'b1 && n < 100) begin
         if (bus.WB_En !== 1'b0 || bus.br_taken !== 1'b0) leak = 1'b1;
         n++;
         tick();
      end
      check({tag, "_stall_cycles"}, 32'(n), 32'd33);
      check({tag, "_gating_leak"}, 32'(leak), 32'd0);
      check({tag, "_result"}, bus.alu_result, exp);
      check({tag, "_wb_done"}, 32'(bus.WB_En), 32'd1);
      check({tag, "_br_done"}, 32'(bus.br_taken), 32'd1);
   endtask

   initial begin
      rst             = 1'b1;
      bus.dest_in     = 5'd0;
      bus.readdata1   = 32'd0;
      bus.readdata2   = 32'd0;
      bus.Immediate   = 32'd0;
      bus.PC          = 32'd0;
      set_op(4'b0000, 32'd0, 32'd0);
      bus.BR_Type     = 2'b11;
      #1;
      check("rst_stall", 32'(bus.stall), 32'd0);
      check("rst_br_taken", 32'(bus.br_taken), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      set_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
      #1;
      check("add_wrap", bus.alu_result, 32'h8000_0000);
      check("add_stall", 32'(bus.stall), 32'd0);
      check("add_wb", 32'(bus.WB_En), 32'd1);
      bus.dest_in     = 5'h1A;
      bus.readdata2   = 32'hDEAD_BEEF;
      bus.MEM_W_En_in = 1'b1;
      #1;
      check("dest_pass", 32'(bus.dest), 32'h0000_001A);
      check("st_value", bus.st_value, 32'hDEAD_BEEF);
      check("memw_pass", 32'(bus.MEM_W_En), 32'd1);

      set_op(4'b0010, 32'h0000_0000, 32'h0000_0001); #1;
      check("sub_wrap", bus.alu_result, 32'hFFFF_FFFF);
      set_op(4'b1011, 32'h8000_0000, 32'h0000_0004); #1;
      check("sra", bus.alu_result, 32'hF800_0000);
      set_op(4'b1010, 32'h8000_0000, 32'h0000_0004); #1;
      check("srl", bus.alu_result, 32'h0800_0000);
      set_op(4'b1000, 32'h0000_0001, 32'h0000_003F); #1;
      check("sll_shamt5", bus.alu_result, 32'h8000_0000);
      set_op(4'b0110, 32'h0F0F_0F0F, 32'h00FF_00FF); #1;
      check("nor", bus.alu_result, 32'hF000_F000);
      set_op(4'b0111, 32'h0F0F_0F0F, 32'h00FF_00FF); #1;
      check("xor", bus.alu_result, 32'h0FF0_0FF0);
      set_op(4'b0100, 32'h0F0F_0F0F, 32'h00FF_00FF); #1;
      check("and", bus.alu_result, 32'h000F_000F);
      set_op(4'b0001, 32'h1234_5678, 32'h1111_1111); #1;
      check("undef_cmd", bus.alu_result, 32'h0000_0000);

      set_op(4'b0000, 32'd0, 32'd5);
      bus.BR_Type   = 2'b10;
      bus.readdata1 = 32'd5;
      bus.PC        = 32'h0000_0100;
      bus.Immediate = 32'd3;
      #1;
      check("bne_equal", 32'(bus.br_taken), 32'd0);
      check("br_addr", bus.br_addr, 32'h0000_010C);
      bus.data2 = 32'd6; #1;
      check("bne_differ", 32'(bus.br_taken), 32'd1);
      bus.BR_Type = 2'b01; #1;
      check("bez_nonzero", 32'(bus.br_taken), 32'd0);
      bus.readdata1 = 32'd0; #1;
      check("bez_zero", 32'(bus.br_taken), 32'd1);
      bus.Immediate = 32'hFFFF_FFFF; #1;
      check("br_addr_neg", bus.br_addr, 32'h0000_00FC);
      tick();

      md_run("mul", 4'b1100, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000, 1'b0);
      set_op(4'b0000, 32'd1, 32'd1); tick();
      md_run("divu", 4'b1101, 32'd100, 32'd7, 32'd14, 1'b0);
      set_op(4'b0000, 32'd1, 32'd1); tick();
      md_run("divu0", 4'b1101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
      set_op(4'b0000, 32'd1, 32'd1); tick();

      set_op(4'b1100, 32'h0000_1234, 32'h0000_0010); #1;
      tick();
      repeat (10) tick();
      check("busy_before_rst", 32'(bus.stall), 32'd1);
      rst = 1'b1; #1;
      check("rst_mid_stall", 32'(bus.stall), 32'd0);
      tick();
      set_op(4'b0000, 32'd2, 32'd3);
      rst = 1'b0; #1;
      check("post_rst_idle", 32'(bus.stall), 32'd0);
      check("post_rst_add", bus.alu_result, 32'd5);
      md_run("mul_after_rst", 4'b1100, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0);

      set_op(4'b0000, 32'd0, 32'd0); tick();
      md_run("b2b_mul1", 4'b1100, 32'd3, 32'd4, 32'd12, 1'b0);
      md_run("b2b_mul2", 4'b1100, 32'd5, 32'd6, 32'd30, 1'b1);
      set_op(4'b0000, 32'd9, 32'd1);
      tick();
      check("b2b_no_dup", 32'(bus.stall), 32'd0);
      check("b2b_next_add", bus.alu_result, 32'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
